// File: rtl/alu_mac_pipe.sv
// Two-stage pipelined signed fixed-point ALU with valid/ready handshake,
// internal multiply-accumulate register and optional saturation.
module alu_mac_pipe #(
  parameter int BUS_WIDTH = 8,
  parameter int FRAC_BITS = 0,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [BUS_WIDTH-1:0] data_a,
  input  logic [BUS_WIDTH-1:0] data_b,
  input  logic [BUS_WIDTH-1:0] imm,
  input  logic [BUS_WIDTH-1:0] sw,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] result,
  output logic                 overflow
);

  localparam int W  = BUS_WIDTH;
  localparam int PW = 2 * BUS_WIDTH;
  localparam int XW = 2 * BUS_WIDTH + 1;

  typedef enum logic [2:0] {
    OP_LOAD = 3'd0,
    OP_ADD  = 3'd1,
    OP_SUB  = 3'd2,
    OP_ADDI = 3'd3,
    OP_MUL  = 3'd4,
    OP_MAC  = 3'd5,
    OP_MACI = 3'd6,
    OP_CLR  = 3'd7
  } op_e;

  op_e                  op_in;
  logic                 adv;
  logic [W-1:0]         mult_d;
  logic [W-1:0]         s1_add_d;
  logic signed [PW-1:0] s1_prod_d;

  logic                 s1_valid_q;
  op_e                  s1_op_q;
  logic [W-1:0]         s1_a_q;
  logic [W-1:0]         s1_sw_q;
  logic [W-1:0]         s1_add_q;
  logic signed [PW-1:0] s1_prod_q;

  logic signed [PW-1:0] scaled;
  logic [XW-1:0]        wide;
  logic [W:0]           hi;
  logic                 ovf_d;
  logic [W-1:0]         res_d;
  logic [W-1:0]         acc_d;

  logic                 out_valid_q;
  logic [W-1:0]         result_q;
  logic                 overflow_q;
  logic [W-1:0]         acc_q;

  assign op_in     = op_e'(op);
  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

  always_comb begin
    mult_d    = (op_in == OP_MACI) ? imm : data_b;
    s1_add_d  = (op_in == OP_ADDI) ? imm : data_b;
    s1_prod_d = {{W{data_a[W-1]}}, data_a} * {{W{mult_d[W-1]}}, mult_d};
  end

  // Everything is widened to 2W+1 bits so one range check covers every op.
  always_comb begin
    scaled = s1_prod_q >>> FRAC_BITS;
    wide   = '0;
    unique case (s1_op_q)
      OP_LOAD: wide = {{(W+1){s1_sw_q[W-1]}}, s1_sw_q};
      OP_ADD, OP_ADDI:
        wide = {{(W+1){s1_a_q[W-1]}}, s1_a_q} + {{(W+1){s1_add_q[W-1]}}, s1_add_q};
      OP_SUB:
        wide = {{(W+1){s1_a_q[W-1]}}, s1_a_q} - {{(W+1){s1_add_q[W-1]}}, s1_add_q};
      OP_MUL:  wide = {scaled[PW-1], scaled};
      OP_MAC, OP_MACI:
        wide = {{(W+1){acc_q[W-1]}}, acc_q} + {scaled[PW-1], scaled};
      OP_CLR:  wide = '0;
      default: wide = '0;
    endcase
  end

  always_comb begin
    hi    = wide[XW-1:W-1];
    ovf_d = !((&hi) || !(|hi));
    res_d = wide[W-1:0];
    if (ovf_d && (SATURATE != 0))
      res_d = wide[XW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    acc_d = acc_q;
    if (s1_op_q == OP_MAC || s1_op_q == OP_MACI || s1_op_q == OP_CLR)
      acc_d = res_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_LOAD;
      s1_a_q      <= '0;
      s1_sw_q     <= '0;
      s1_add_q    <= '0;
      s1_prod_q   <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      acc_q       <= '0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      out_valid_q <= s1_valid_q;
      if (in_valid) begin
        s1_op_q   <= op_in;
        s1_a_q    <= data_a;
        s1_sw_q   <= sw;
        s1_add_q  <= s1_add_d;
        s1_prod_q <= s1_prod_d;
      end
      // Output and acc only move on a real transfer so results stay put otherwise.
      if (s1_valid_q) begin
        result_q   <= res_d;
        overflow_q <= ovf_d;
        acc_q      <= acc_d;
      end
    end
  end

endmodule
